// File: rtl/seq_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// seq_pkg: state encodings and helpers shared by compute_sequencer
// Rev 1.0
// ------------------------------------------------------------------
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RUN_PE  = 3'd2,
    S_RUN_3X3 = 3'd3,
    S_RUN_2X2 = 3'd4,
    S_DISPLAY = 3'd5,
    S_DONE    = 3'd6,
    S_ERROR   = 3'd7
  } state_e;

  // Display block's S_DONE_DISPLAY code
  localparam logic [2:0] DISP_DONE_CODE = 3'd4;

  function automatic logic is_timed(input state_e s);
    return (s == S_RUN_PE) || (s == S_RUN_3X3) || (s == S_RUN_2X2) || (s == S_DISPLAY);
  endfunction

  function automatic logic is_busy(input state_e s);
    return (s != S_IDLE) && (s != S_DONE) && (s != S_ERROR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/stage_timer.sv
`default_nettype none
// ------------------------------------------------------------------
// stage_timer: per-stage residency counter with TIMEOUT compare
// Rev 1.0
// ------------------------------------------------------------------
module stage_timer #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/compute_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// compute_sequencer: operand load, PE/3x3/2x2 engine and display sequencing
// Rev 1.0
// ------------------------------------------------------------------
module compute_sequencer
  import seq_pkg::*;
#(
  parameter int LOAD_CYCLES = 4,
  parameter int TIMEOUT     = 1024,
  parameter int CNT_W       = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       done_pe,
  input  logic       done_3x3,
  input  logic       done_2x2,
  input  logic [2:0] state_display_i,
  output logic       load_en,
  output logic [1:0] load_addr,
  output logic       start_pe,
  output logic       start_3x3,
  output logic       start_2x2,
  output logic       run_display,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] err_stage,
  output logic [2:0] current_state
);

  localparam logic [1:0] LOAD_LAST = 2'(LOAD_CYCLES - 1);

  state_e     state_q, state_d;
  logic       first_q;
  logic       entering;
  logic       tmr_expired;
  logic       load_en_q, start_pe_q, start_3x3_q, start_2x2_q;
  logic       run_display_q, busy_q, done_q, error_q;
  logic [1:0] load_addr_q;
  logic [2:0] err_stage_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= entering;
    end
  end

  // Engine done is only honoured after the entry cycle (first_q low)
  always_comb begin
    state_d = state_q;
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: if (start) state_d = S_LOAD;
        S_LOAD:    if (load_addr_q == LOAD_LAST) state_d = S_RUN_PE;
        S_RUN_PE:  if (done_pe && !first_q) state_d = S_RUN_3X3;
                   else if (tmr_expired) state_d = S_ERROR;
        S_RUN_3X3: if (done_3x3 && !first_q) state_d = S_RUN_2X2;
                   else if (tmr_expired) state_d = S_ERROR;
        S_RUN_2X2: if (done_2x2 && !first_q) state_d = S_DISPLAY;
                   else if (tmr_expired) state_d = S_ERROR;
        S_DISPLAY: if (state_display_i == DISP_DONE_CODE) state_d = S_DONE;
                   else if (tmr_expired) state_d = S_ERROR;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  assign entering = (state_d != state_q);

  stage_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (entering),
    .en      (is_timed(state_q)),
    .expired (tmr_expired)
  );

  // Outputs decoded from the next state so they line up with state_q
  always_ff @(posedge clk) begin
    if (reset) begin
      load_en_q     <= 1'b0;
      load_addr_q   <= 2'd0;
      start_pe_q    <= 1'b0;
      start_3x3_q   <= 1'b0;
      start_2x2_q   <= 1'b0;
      run_display_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      err_stage_q   <= 3'd0;
    end else begin
      load_en_q     <= (state_d == S_LOAD);
      load_addr_q   <= ((state_d == S_LOAD) && (state_q == S_LOAD)) ? load_addr_q + 2'd1 : 2'd0;
      start_pe_q    <= entering && (state_d == S_RUN_PE);
      start_3x3_q   <= entering && (state_d == S_RUN_3X3);
      start_2x2_q   <= entering && (state_d == S_RUN_2X2);
      run_display_q <= (state_d == S_DISPLAY);
      busy_q        <= is_busy(state_d);
      done_q        <= (state_d == S_DONE);
      error_q       <= (state_d == S_ERROR);
      if (entering && (state_d == S_ERROR)) begin
        err_stage_q <= state_q;
      end else if (entering && (state_d == S_LOAD)) begin
        err_stage_q <= 3'd0;
      end
    end
  end

  assign load_en       = load_en_q;
  assign load_addr     = load_addr_q;
  assign start_pe      = start_pe_q;
  assign start_3x3     = start_3x3_q;
  assign start_2x2     = start_2x2_q;
  assign run_display   = run_display_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign err_stage     = err_stage_q;
  assign current_state = state_q;

endmodule
`default_nettype wire
